// File: rtl/ex_mem_pkg.sv
// Shared constants for the execute/memory datapath slice: datapath width
// and the ALU operation encodings driven by the control unit.
package ex_mem_pkg;

  localparam int DATA_W         = 64;
  localparam int BYTES_PER_WORD = DATA_W / 8;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_LSL   = 4'b0011;
  localparam logic [3:0] ALU_LSR   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

endpackage

// File: rtl/ex_mem_dmem.sv
// Byte-addressed data memory: combinational big-endian 8-byte read, clocked
// 8-byte write, synchronous clear. Byte indices wrap modulo MEM_BYTES.
module ex_mem_dmem
  import ex_mem_pkg::*;
#(
  parameter int MEM_BYTES = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rd_en_i,
  input  logic              wr_en_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0]    mem_q [MEM_BYTES];
  logic [AW-1:0] base;

  // Upper address bits are deliberately ignored so accesses alias into the array.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[DATA_W-1:AW];
  assign base           = addr_i[AW-1:0];

  // Byte b of the word sits at base+b; AW-bit addition gives the wrap for free.
  always_comb begin
    rdata_o = '0;
    if (rd_en_i) begin
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
        rdata_o[DATA_W-1-8*b -: 8] = mem_q[base + AW'(b)];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
        mem_q[base + AW'(b)] <= wdata_i[DATA_W-1-8*b -: 8];
      end
    end
  end

endmodule

// File: rtl/ex_mem_datapath.sv
// Execute/memory slice: 64-bit ALU with zero flag, branch-target adder and
// the data memory. Only the memory holds state.
module ex_mem_datapath
  import ex_mem_pkg::*;
#(
  parameter int MEM_BYTES = 256
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [3:0]        ALUCtrl,
  input  logic [DATA_W-1:0] BusA,
  input  logic [DATA_W-1:0] BusB,
  output logic [DATA_W-1:0] BusW,
  output logic              Zero,
  input  logic [DATA_W-1:0] CurrentPC,
  input  logic [DATA_W-1:0] ExtendedImm,
  output logic [DATA_W-1:0] BranchPC,
  input  logic [DATA_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              MemoryRead,
  input  logic              MemoryWrite,
  output logic [DATA_W-1:0] ReadData
);

  logic [DATA_W-1:0] alu_res;

  // Undefined opcodes yield zero so the flag and result never go X.
  always_comb begin
    alu_res = '0;
    case (ALUCtrl)
      ALU_AND:   alu_res = BusA & BusB;
      ALU_OR:    alu_res = BusA | BusB;
      ALU_ADD:   alu_res = BusA + BusB;
      ALU_SUB:   alu_res = BusA - BusB;
      ALU_PASSB: alu_res = BusB;
      ALU_NOR:   alu_res = ~(BusA | BusB);
      ALU_LSL:   alu_res = BusA << BusB[5:0];
      ALU_LSR:   alu_res = BusA >> BusB[5:0];
      default:   alu_res = '0;
    endcase
  end

  assign BusW = alu_res;
  assign Zero = (alu_res == '0);

  // Offset is in words; shifting by two converts it to a byte displacement.
  assign BranchPC = CurrentPC + (ExtendedImm << 2);

  ex_mem_dmem #(
    .MEM_BYTES (MEM_BYTES)
  ) u_dmem (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .addr_i  (Address),
    .wdata_i (WriteData),
    .rd_en_i (MemoryRead),
    .wr_en_i (MemoryWrite),
    .rdata_o (ReadData)
  );

endmodule

// File: tb/tb_ex_mem_datapath.sv
// Self-checking bench for ex_mem_datapath: directed cases plus randomized
// traffic compared against a byte-array reference model.
module tb_ex_mem_datapath;

  localparam int MB = 256;

  logic        Clk;
  logic        Reset;
  logic [3:0]  ALUCtrl;
  logic [63:0] BusA, BusB, BusW;
  logic        Zero;
  logic [63:0] CurrentPC, ExtendedImm, BranchPC;
  logic [63:0] Address, WriteData, ReadData;
  logic        MemoryRead, MemoryWrite;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] ref_mem [MB];

  ex_mem_datapath #(.MEM_BYTES(MB)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .ALUCtrl     (ALUCtrl),
    .BusA        (BusA),
    .BusB        (BusB),
    .BusW        (BusW),
    .Zero        (Zero),
    .CurrentPC   (CurrentPC),
    .ExtendedImm (ExtendedImm),
    .BranchPC    (BranchPC),
    .Address     (Address),
    .WriteData   (WriteData),
    .MemoryRead  (MemoryRead),
    .MemoryWrite (MemoryWrite),
    .ReadData    (ReadData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] alu_ref(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    int sh;
    sh = int'(b % 64);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return b;
      4'd12:   return ~(a | b);
      4'd3:    return a << sh;
      4'd4:    return a >> sh;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] mem_rd_ref(input logic [63:0] addr);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < 8; i++) v = (v << 8) | 64'(ref_mem[int'((addr + 64'(i)) % MB)]);
    return v;
  endfunction

  // Advance one rising edge, applying the memory rules to the model.
  task automatic tick();
    @(posedge Clk);
    if (Reset) begin
      for (int i = 0; i < MB; i++) ref_mem[i] = 8'h00;
    end else if (MemoryWrite) begin
      for (int i = 0; i < 8; i++)
        ref_mem[int'((Address + 64'(i)) % MB)] = 8'(WriteData >> (8 * (7 - i)));
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [63:0] w;
    #1;
    w = alu_ref(ALUCtrl, BusA, BusB);
    chk({tag, "_busw"}, BusW, w);
    chk({tag, "_zero"}, 64'(Zero), 64'(w == 64'd0));
    chk({tag, "_bpc"}, BranchPC, CurrentPC + ExtendedImm * 64'd4);
    chk({tag, "_rd"}, ReadData, MemoryRead ? mem_rd_ref(Address) : 64'd0);
  endtask

  task automatic mem_write(input logic [63:0] a, input logic [63:0] d);
    Address = a; WriteData = d; MemoryWrite = 1'b1; MemoryRead = 1'b0;
    tick();
    MemoryWrite = 1'b0;
  endtask

  task automatic mem_read(input string tag, input logic [63:0] a, input logic [63:0] exp);
    Address = a; MemoryRead = 1'b1; MemoryWrite = 1'b0;
    #1;
    chk(tag, ReadData, exp);
  endtask

  initial begin
    Reset = 1'b1; ALUCtrl = 4'd0; BusA = '0; BusB = '0;
    CurrentPC = '0; ExtendedImm = '0; Address = '0; WriteData = '1;
    MemoryRead = 1'b0; MemoryWrite = 1'b1;
    #2;
    tick();
    Reset = 1'b0; MemoryWrite = 1'b0;
    mem_read("rst_rd0", 64'h0, 64'h0);
    mem_read("rst_rd_f8", 64'hF8, 64'h0);

    // ALU directed cases
    ALUCtrl = 4'b0110; BusA = 64'd5; BusB = 64'd5; #1;
    chk("sub_res", BusW, 64'd0); chk("sub_zero", 64'(Zero), 64'd1);
    ALUCtrl = 4'b0010; BusA = '1; BusB = 64'd1; #1;
    chk("add_wrap", BusW, 64'd0); chk("add_zero", 64'(Zero), 64'd1);
    BusA = 64'hF0; BusB = 64'h3C;
    ALUCtrl = 4'b0000; #1; chk("and", BusW, 64'h30);
    ALUCtrl = 4'b0001; #1; chk("or", BusW, 64'hFC);
    ALUCtrl = 4'b1100; #1; chk("nor", BusW, 64'hFFFF_FFFF_FFFF_FF03);
    ALUCtrl = 4'b0111; #1; chk("passb", BusW, 64'h3C); chk("passb_zero", 64'(Zero), 64'd0);
    ALUCtrl = 4'b0011; BusA = 64'd1; BusB = 64'd67; #1; chk("lsl", BusW, 64'd8);
    ALUCtrl = 4'b0100; BusA = 64'h8000_0000_0000_0000; BusB = 64'd63; #1; chk("lsr", BusW, 64'd1);
    ALUCtrl = 4'b1111; BusA = 64'd9; BusB = 64'd7; #1;
    chk("undef_res", BusW, 64'd0); chk("undef_zero", 64'(Zero), 64'd1);

    // Branch target
    CurrentPC = 64'h100; ExtendedImm = 64'd3; #1; chk("bpc_fwd", BranchPC, 64'h10C);
    ExtendedImm = 64'hFFFF_FFFF_FFFF_FFFE; #1; chk("bpc_back", BranchPC, 64'hF8);

    // Store / load
    mem_write(64'h10, 64'h0123_4567_89AB_CDEF);
    mem_read("ld_10", 64'h10, 64'h0123_4567_89AB_CDEF);
    mem_read("ld_11", 64'h11, 64'h2345_6789_ABCD_EF00);
    MemoryRead = 1'b0; #1; chk("rd_off", ReadData, 64'd0);

    // Wrap-around
    mem_write(64'hFC, 64'h1122_3344_5566_7788);
    mem_read("ld_1fc", 64'h1FC, 64'h1122_3344_5566_7788);
    mem_read("ld_0_top", 64'h0, mem_rd_ref(64'h0));
    chk("byte0", ReadData >> 56, 64'h55);

    // Same-cycle read/write collision
    mem_write(64'h20, 64'hAAAA_BBBB_CCCC_DDDD);
    Address = 64'h20; WriteData = 64'h1357_9BDF_2468_ACE0;
    MemoryRead = 1'b1; MemoryWrite = 1'b1; #1;
    chk("coll_pre", ReadData, 64'hAAAA_BBBB_CCCC_DDDD);
    tick();
    MemoryWrite = 1'b0; #1;
    chk("coll_post", ReadData, 64'h1357_9BDF_2468_ACE0);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      ALUCtrl     = 4'($urandom_range(0, 15));
      BusA        = {$urandom, $urandom};
      BusB        = ($urandom_range(0, 3) == 0) ? BusA : {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) BusB = 64'($urandom_range(0, 127));
      CurrentPC   = {$urandom, $urandom};
      ExtendedImm = {$urandom, $urandom};
      Address     = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 300));
      WriteData   = {$urandom, $urandom};
      MemoryRead  = 1'($urandom_range(0, 3) != 0);
      MemoryWrite = 1'($urandom_range(0, 1));
      Reset       = 1'($urandom_range(0, 60) == 0);
      check_all("rnd");
      tick();
      Reset = 1'b0;
    end

    // Mid-stream reset with a colliding write, then all reads zero
    MemoryWrite = 1'b0;
    mem_write(64'h40, 64'hDEAD_BEEF_0000_1111);
    mem_read("pre_rst", 64'h40, 64'hDEAD_BEEF_0000_1111);
    Reset = 1'b1; Address = 64'h48; WriteData = '1; MemoryWrite = 1'b1;
    tick();
    Reset = 1'b0; MemoryWrite = 1'b0;
    mem_read("post_rst_40", 64'h40, 64'h0);
    mem_read("post_rst_48", 64'h48, 64'h0);
    mem_read("post_rst_10", 64'h10, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
